stream_mux_n: RTL and testbench

Parametrised N-channel, W-bit packet-aware stream multiplexer with a registered output stage. It generalises the team's combinational 2:1 bit mux to CHANNELS valid/ready streams of WIDTH bits. Channel selection is either by an external select or by round-robin arbitration, and a granted channel stays locked until its packet ends. It sits between per-source packet producers and a single downstream consumer.

---
 rtl/stream_mux_n.sv | 148 ++++++++++++++
 tb/tb_stream_mux_n.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_n.sv
// stream_mux_n: N-channel packet-aware valid/ready stream multiplexer with a
// registered output stage. A granted channel stays locked until its last beat.
// Optional feature macro: STREAM_MUX_RR_EN. When it is defined, round-robin
// arbitration is compiled in and selected by i_rr_mode. When it is not
// defined, only fixed select is available.
module stream_mux_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS*WIDTH-1:0] i_in_data,
    input  logic [CHANNELS-1:0]       i_in_valid,
    input  logic [CHANNELS-1:0]       i_in_last,
    output logic [CHANNELS-1:0]       o_in_ready,
    input  logic [SEL_W-1:0]          i_sel,
    input  logic                      i_rr_mode,
    output logic [WIDTH-1:0]          o_out_data,
    output logic                      o_out_valid,
    output logic                      o_out_last,
    output logic [SEL_W-1:0]          o_out_chan,
    input  logic                      i_out_ready,
    output logic                      o_busy
);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t             r_state, w_state_nxt;
    logic [SEL_W-1:0]   r_lock_chan, w_lock_chan_nxt;
    logic               w_slot_free;
    logic               w_grant;
    logic [SEL_W-1:0]   w_g;
    logic               w_accept;
    logic               w_beat_last;
    logic [CHANNELS-1:0] w_ready;

    assign w_slot_free = !o_out_valid || i_out_ready;

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0] r_rr_last;
    logic             w_rr_grant;
    logic [SEL_W-1:0] w_rr_g;

    // Round-robin search: the nearest valid channel after r_rr_last wins.
    // Scanning from farthest to nearest leaves the nearest one assigned.
    always_comb begin
        int idx;
        idx        = 0;
        w_rr_grant = 1'b0;
        w_rr_g     = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = int'(r_rr_last) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (i_in_valid[idx]) begin
                w_rr_grant = 1'b1;
                w_rr_g     = idx[SEL_W-1:0];
            end
        end
    end

    // The pointer moves only when a packet finishes, so a packet counts once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_rr_last <= SEL_W'(CHANNELS - 1);
        else if (w_accept && w_beat_last)
            r_rr_last <= w_g;
    end
`else
    logic w_unused_rr_mode;
    assign w_unused_rr_mode = i_rr_mode;
`endif

    // Grant selection: the locked channel, else the arbitration or select result.
    always_comb begin
        w_grant = 1'b0;
        w_g     = '0;
        if (r_state == S_LOCKED) begin
            w_grant = 1'b1;
            w_g     = r_lock_chan;
        end
`ifdef STREAM_MUX_RR_EN
        else if (i_rr_mode) begin
            w_grant = w_rr_grant;
            w_g     = w_rr_g;
        end
`endif
        else if (int'(i_sel) < CHANNELS) begin
            w_grant = 1'b1;
            w_g     = i_sel;
        end
    end

    // One-hot ready toward the granted channel. It is held low while in reset.
    always_comb begin
        w_ready = '0;
        if (w_grant && w_slot_free && i_rst_n)
            w_ready[w_g] = 1'b1;
    end

    assign o_in_ready  = w_ready;
    assign w_accept    = w_grant && w_slot_free && i_in_valid[w_g];
    assign w_beat_last = i_in_last[w_g];
    assign o_busy      = (r_state == S_LOCKED);

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_lock_chan <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_chan <= w_lock_chan_nxt;
        end
    end

    // Next state: lock on a non-last first beat, unlock on the last beat.
    always_comb begin
        w_state_nxt     = r_state;
        w_lock_chan_nxt = r_lock_chan;
        if (w_accept) begin
            if (r_state == S_IDLE && !w_beat_last) begin
                w_state_nxt     = S_LOCKED;
                w_lock_chan_nxt = w_g;
            end else if (r_state == S_LOCKED && w_beat_last) begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    // Output register stage. It loads on accept and drains when downstream takes the beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_out_last  <= 1'b0;
            o_out_chan  <= '0;
        end else if (w_accept) begin
            o_out_valid <= 1'b1;
            o_out_data  <= i_in_data[int'(w_g)*WIDTH +: WIDTH];
            o_out_last  <= w_beat_last;
            o_out_chan  <= w_g;
        end else if (i_out_ready) begin
            o_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
// Testbench for stream_mux_n. It uses a directed vector table, hand-written
// corner sequences and a randomized run checked against a cycle reference model.
module tb_stream_mux_n;

`ifdef STREAM_MUX_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_last, in_ready;
    logic [1:0]  sel;
    logic        rr_mode;
    logic [7:0]  out_data;
    logic        out_valid, out_last, out_ready, busy;
    logic [1:0]  out_chan;

    logic [23:0] d3;
    logic [2:0]  v3, l3, r3;
    logic [1:0]  s3;
    logic [7:0]  od3;
    logic        ov3, ol3, b3;
    logic [1:0]  oc3;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stream_mux_n #(.WIDTH(8), .CHANNELS(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_data(in_data), .i_in_valid(in_valid),
        .i_in_last(in_last), .o_in_ready(in_ready), .i_sel(sel), .i_rr_mode(rr_mode),
        .o_out_data(out_data), .o_out_valid(out_valid), .o_out_last(out_last),
        .o_out_chan(out_chan), .i_out_ready(out_ready), .o_busy(busy)
    );

    stream_mux_n #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_data(d3), .i_in_valid(v3),
        .i_in_last(l3), .o_in_ready(r3), .i_sel(s3), .i_rr_mode(1'b0),
        .o_out_data(od3), .o_out_valid(ov3), .o_out_last(ol3),
        .o_out_chan(oc3), .i_out_ready(1'b1), .o_busy(b3)
    );

    typedef struct {
        logic [1:0] sel;
        logic [3:0] v;
        logic [3:0] l;
        logic [7:0] d;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ol;
        logic [1:0] e_oc;
        logic       e_busy;
    } vec_t;

    vec_t tbl[18];

    // reference model state
    int m_locked, m_lock, m_rr, m_ov, m_od, m_ol, m_oc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_locked = 0; m_lock = 0; m_rr = 3;
        m_ov = 0; m_od = 0; m_ol = 0; m_oc = 0;
    endtask

    // Checks the DUT against the model for the current inputs, then advances the model by one edge.
    task automatic model_step();
        int  g, slot, gr, acc, c;
        logic [3:0] exp_rdy;
        slot = (m_ov == 0 || out_ready) ? 1 : 0;
        gr = 0; g = 0;
        if (m_locked != 0) begin
            gr = 1; g = m_lock;
        end else if (RR_EN && rr_mode) begin
            for (int k = 1; k <= 4; k++) begin
                c = (m_rr + k) % 4;
                if (gr == 0 && in_valid[c]) begin gr = 1; g = c; end
            end
        end else begin
            gr = 1; g = int'(sel);
        end
        exp_rdy = (gr != 0 && slot != 0) ? 4'(1 << g) : 4'b0;
        chk("rnd_ready", in_ready, exp_rdy);
        chk("rnd_valid", out_valid, m_ov);
        chk("rnd_data",  out_data, m_od);
        chk("rnd_last",  out_last, m_ol);
        chk("rnd_chan",  out_chan, m_oc);
        chk("rnd_busy",  busy, m_locked);
        acc = (gr != 0 && slot != 0 && in_valid[g]) ? 1 : 0;
        if (acc != 0) begin
            m_od = int'(in_data[g*8 +: 8]);
            m_ol = int'(in_last[g]);
            m_oc = g;
            m_ov = 1;
            if (m_locked == 0 && !in_last[g]) begin
                m_locked = 1; m_lock = g;
            end else if (m_locked != 0 && in_last[g]) begin
                m_locked = 0;
            end
            if (in_last[g]) m_rr = g;
        end else if (out_ready) begin
            m_ov = 0;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = '0; in_last = '0;
        sel = 2'd0; rr_mode = 1'b0; out_ready = 1'b1;
        d3 = 24'h332211; v3 = 3'b111; l3 = 3'b000; s3 = 2'd3;

        //               sel  v        l        d      ordy  rdy      ov  od     ol  oc  busy
        tbl[0]  = '{2'd2, 4'b0100, 4'b0000, 8'h11, 1'b1, 4'b0100, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{2'd2, 4'b0100, 4'b0000, 8'h22, 1'b1, 4'b0100, 1'b1, 8'h11, 1'b0, 2'd2, 1'b1};
        tbl[2]  = '{2'd2, 4'b0100, 4'b0100, 8'h33, 1'b1, 4'b0100, 1'b1, 8'h22, 1'b0, 2'd2, 1'b1};
        tbl[3]  = '{2'd2, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0100, 1'b1, 8'h33, 1'b1, 2'd2, 1'b0};
        tbl[4]  = '{2'd2, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0100, 1'b0, 8'h33, 1'b1, 2'd2, 1'b0};
        tbl[5]  = '{2'd2, 4'b0101, 4'b0000, 8'h44, 1'b1, 4'b0100, 1'b0, 8'h33, 1'b1, 2'd2, 1'b0};
        tbl[6]  = '{2'd0, 4'b0101, 4'b0000, 8'h55, 1'b1, 4'b0100, 1'b1, 8'h44, 1'b0, 2'd2, 1'b1};
        tbl[7]  = '{2'd0, 4'b0101, 4'b0100, 8'h66, 1'b1, 4'b0100, 1'b1, 8'h55, 1'b0, 2'd2, 1'b1};
        tbl[8]  = '{2'd0, 4'b0001, 4'b0001, 8'h77, 1'b1, 4'b0001, 1'b1, 8'h66, 1'b1, 2'd2, 1'b0};
        tbl[9]  = '{2'd0, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0001, 1'b1, 8'h77, 1'b1, 2'd0, 1'b0};
        tbl[10] = '{2'd1, 4'b0010, 4'b0000, 8'hA1, 1'b1, 4'b0010, 1'b0, 8'h77, 1'b1, 2'd0, 1'b0};
        tbl[11] = '{2'd1, 4'b0010, 4'b0000, 8'hA2, 1'b0, 4'b0000, 1'b1, 8'hA1, 1'b0, 2'd1, 1'b1};
        tbl[12] = '{2'd1, 4'b0010, 4'b0000, 8'hA2, 1'b0, 4'b0000, 1'b1, 8'hA1, 1'b0, 2'd1, 1'b1};
        tbl[13] = '{2'd1, 4'b0010, 4'b0000, 8'hA2, 1'b0, 4'b0000, 1'b1, 8'hA1, 1'b0, 2'd1, 1'b1};
        tbl[14] = '{2'd1, 4'b0010, 4'b0000, 8'hA2, 1'b0, 4'b0000, 1'b1, 8'hA1, 1'b0, 2'd1, 1'b1};
        tbl[15] = '{2'd1, 4'b0010, 4'b0010, 8'hA2, 1'b1, 4'b0010, 1'b1, 8'hA1, 1'b0, 2'd1, 1'b1};
        tbl[16] = '{2'd1, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0010, 1'b1, 8'hA2, 1'b1, 2'd1, 1'b0};
        tbl[17] = '{2'd1, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0010, 1'b0, 8'hA2, 1'b1, 2'd1, 1'b0};

        // reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #4;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data",  out_data, 8'h00);
        chk("rst_chan",  out_chan, 2'd0);
        chk("rst_busy",  busy, 1'b0);
        chk("rst_ready", in_ready, 4'b0001);
        chk("inv_sel_ready", r3, 3'b000);
        tick();

        // directed table: fixed-mode packet, lock hold, backpressure
        for (int i = 0; i < 18; i++) begin
            sel = tbl[i].sel; in_valid = tbl[i].v; in_last = tbl[i].l;
            in_data = {4{tbl[i].d}}; out_ready = tbl[i].ordy;
            #4;
            chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_data", i),  out_data, tbl[i].e_od);
            chk($sformatf("tbl%0d_last", i),  out_last, tbl[i].e_ol);
            chk($sformatf("tbl%0d_chan", i),  out_chan, tbl[i].e_oc);
            chk($sformatf("tbl%0d_busy", i),  busy, tbl[i].e_busy);
            chk("inv_sel_valid", ov3, 1'b0);
            tick();
        end

        // reset asserted in the middle of a packet
        sel = 2'd2; in_valid = 4'b0100; in_last = 4'b0000; in_data = {4{8'h11}};
        out_ready = 1'b1; rr_mode = 1'b0;
        tick();
        in_data = {4{8'h22}};
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_busy",  busy, 1'b0);
        chk("midrst_ready", in_ready, 4'b0000);
        chk("midrst_data",  out_data, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
`ifdef STREAM_MUX_RR_EN
        rr_mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #4 chk("rr_all", in_ready, 32'(1 << (i % 4)));
            tick();
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #4 chk("rr_odd", in_ready, (i % 2 == 0) ? 32'h2 : 32'h8);
            tick();
        end
`else
        #4;
        chk("postrst_ready", in_ready, 4'b0100);
        chk("postrst_busy",  busy, 1'b0);
        chk("postrst_chan",  out_chan, 2'd0);
        tick();
        #4;
        chk("postrst_ov",   out_valid, 1'b1);
        chk("postrst_od",   out_data, 8'h22);
        chk("postrst_busy1", busy, 1'b1);
        tick();
`endif

        // invalid select on the 3-channel instance, then a valid select
        for (int i = 0; i < 3; i++) begin
            #4;
            chk("inv_sel_ready", r3, 3'b000);
            chk("inv_sel_valid", ov3, 1'b0);
            tick();
        end
        s3 = 2'd2;
        #4 chk("sel2_ch3_ready", r3, 3'b100);
        tick();
        #4 chk("sel2_ch3_data", od3, 8'h33);
        s3 = 2'd3;
        tick();

        // randomized run against the reference model
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            in_valid  = 4'($urandom_range(0, 15));
            in_last   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            in_data   = $urandom;
            sel       = 2'($urandom_range(0, 3));
            rr_mode   = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #4;
            model_step();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
